// File: rtl/rom_port_arbiter.sv
// Shares one synchronous ROM RAM between the HPS download writer, the video fetcher and the CPU.
// Define ROM_DL_CHECKSUM_EN to add the dl_sum / dl_count download checksum outputs.
//
// state   | meaning
// IDLE    | arbitrate: buffered write, then video, then CPU (starvation can promote CPU)
// WRITE   | mem_we high for one cycle with the buffered byte
// RD_WAIT | read address on mem_addr, RAM access in progress
// RD_DONE | mem_rdata valid, latched into the granted requester
module rom_port_arbiter #(
  parameter int RESET_HOLD = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  output logic        cpu_ack,
  output logic [7:0]  cpu_data,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_data,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        core_rst,
  output logic        dl_ovf
`ifdef ROM_DL_CHECKSUM_EN
  ,
  output logic [7:0]  dl_sum,
  output logic [15:0] dl_count
`endif
);

  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam int STV_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, RD_DONE} state_t;

  state_t      state_q, state_d;
  logic        wb_valid_q, wb_valid_d;
  logic [15:0] wb_addr_q, wb_addr_d;
  logic [7:0]  wb_data_q, wb_data_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic        sel_cpu_q, sel_cpu_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        vid_ack_q, vid_ack_d;
  logic [7:0]  cpu_data_q, cpu_data_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic        dl_ovf_q, dl_ovf_d;
  logic        core_rst_q, core_rst_d;
  logic        dn_dl_q;

  logic wb_accept;
  logic dl_rise;
  logic wr_pend;
  logic cpu_wins;

  // The buffer frees up during WRITE, so a byte arriving then is still taken.
  assign wb_accept = dn_wr && (!wb_valid_q || (state_q == WRITE));
  assign dl_rise   = dn_download && !dn_dl_q;
  assign wr_pend   = wb_valid_q || dn_wr;
  assign cpu_wins  = cpu_req && (!vid_req || (starve_q == STV_W'(STARVE_MAX)));

  always_comb begin
    state_d     = state_q;
    sel_cpu_d   = sel_cpu_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_data_d  = cpu_data_q;
    vid_data_d  = vid_data_q;

    case (state_q)
      IDLE: begin
        if (wr_pend) begin
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_addr_d  = wb_valid_q ? wb_addr_q : dn_addr;
          mem_wdata_d = wb_valid_q ? wb_data_q : dn_data;
        end else if (cpu_wins) begin
          state_d    = RD_WAIT;
          sel_cpu_d  = 1'b1;
          mem_addr_d = cpu_addr;
          starve_d   = '0;
        end else if (vid_req) begin
          state_d    = RD_WAIT;
          sel_cpu_d  = 1'b0;
          mem_addr_d = vid_addr;
          if (cpu_req) starve_d = starve_q + STV_W'(1);
        end
      end
      WRITE:   state_d = IDLE;
      RD_WAIT: state_d = RD_DONE;
      RD_DONE: begin
        state_d = IDLE;
        if (sel_cpu_q) begin
          cpu_ack_d  = 1'b1;
          cpu_data_d = mem_rdata;
        end else begin
          vid_ack_d  = 1'b1;
          vid_data_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (wb_accept) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = dn_addr;
      wb_data_d  = dn_data;
    end else if (state_q == WRITE) begin
      wb_valid_d = 1'b0;
    end

    dl_ovf_d = (dn_wr && !wb_accept) || (dl_ovf_q && !dl_rise);

    // Reloading on every download cycle makes a re-raise during the hold restart it.
    if (dn_download) begin
      hold_d = HOLD_W'(RESET_HOLD);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end else begin
      hold_d = hold_q;
    end
    core_rst_d = dn_download || (hold_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      starve_q    <= '0;
      hold_q      <= HOLD_W'(RESET_HOLD);
      sel_cpu_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_data_q  <= '0;
      vid_data_q  <= '0;
      dl_ovf_q    <= 1'b0;
      core_rst_q  <= 1'b1;
      dn_dl_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      starve_q    <= starve_d;
      hold_q      <= hold_d;
      sel_cpu_q   <= sel_cpu_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_data_q  <= cpu_data_d;
      vid_data_q  <= vid_data_d;
      dl_ovf_q    <= dl_ovf_d;
      core_rst_q  <= core_rst_d;
      dn_dl_q     <= dn_download;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign cpu_ack   = cpu_ack_q;
  assign vid_ack   = vid_ack_q;
  assign cpu_data  = cpu_data_q;
  assign vid_data  = vid_data_q;
  assign dl_ovf    = dl_ovf_q;
  assign core_rst  = core_rst_q || dn_download;

`ifdef ROM_DL_CHECKSUM_EN
  logic [7:0]  dl_sum_q, dl_sum_d;
  logic [15:0] dl_count_q, dl_count_d;

  always_comb begin
    dl_sum_d   = dl_rise ? 8'h00 : dl_sum_q;
    dl_count_d = dl_rise ? 16'h0000 : dl_count_q;
    if (wb_accept) begin
      dl_sum_d   = dl_sum_d + dn_data;
      dl_count_d = dl_count_d + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_sum_q   <= '0;
      dl_count_q <= '0;
    end else begin
      dl_sum_q   <= dl_sum_d;
      dl_count_q <= dl_count_d;
    end
  end

  assign dl_sum   = dl_sum_q;
  assign dl_count = dl_count_q;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter with a 64K x 8 synchronous RAM model.
module tb_rom_port_arbiter;
  localparam int RESET_HOLD = 1024;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        dn_download = 1'b0;
  logic        dn_wr = 1'b0;
  logic [15:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_data;
  logic        vid_req = 1'b0;
  logic [15:0] vid_addr = '0;
  logic        vid_ack;
  logic [7:0]  vid_data;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        core_rst;
  logic        dl_ovf;
`ifdef ROM_DL_CHECKSUM_EN
  logic [7:0]  dl_sum;
  logic [15:0] dl_count;
`endif

  logic        tb_we = 1'b0;
  logic [15:0] tb_addr = '0;
  logic [7:0]  tb_wdata = '0;
  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int ack_cnt = 0;
  int lat, idx, maxrun, run, low, n, we0, a0;
  logic [9:0] seq;

  rom_port_arbiter #(.RESET_HOLD(RESET_HOLD), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .dn_download(dn_download),
    .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .core_rst(core_rst), .dl_ovf(dl_ovf)
`ifdef ROM_DL_CHECKSUM_EN
    , .dl_sum(dl_sum), .dl_count(dl_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_wdata;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) we_cnt = we_cnt + 1;
    if (cpu_ack || vid_ack) ack_cnt = ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_addr = a; tb_wdata = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic check_reset(input string p);
    check({p, "_mem_addr"},  32'(mem_addr), 32'h0);
    check({p, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    check({p, "_mem_we"},    32'(mem_we), 32'h0);
    check({p, "_cpu_ack"},   32'(cpu_ack), 32'h0);
    check({p, "_vid_ack"},   32'(vid_ack), 32'h0);
    check({p, "_cpu_data"},  32'(cpu_data), 32'h0);
    check({p, "_vid_data"},  32'(vid_data), 32'h0);
    check({p, "_dl_ovf"},    32'(dl_ovf), 32'h0);
    check({p, "_core_rst"},  32'(core_rst), 32'h1);
`ifdef ROM_DL_CHECKSUM_EN
    check({p, "_dl_sum"},    32'(dl_sum), 32'h0);
    check({p, "_dl_count"},  32'(dl_count), 32'h0);
`endif
  endtask

  // Counts negedges with core_rst high, stopping at the first low one.
  task automatic measure_rst(output int cnt);
    cnt = 0;
    for (int i = 0; i < RESET_HOLD + 20; i++) begin
      @(negedge clk);
      if (core_rst) cnt++;
      else break;
    end
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1 check_reset("rst");
    preload(16'h1234, 8'h5A);
    preload(16'h0100, 8'h33);
    preload(16'h0021, 8'h77);
    tick();
    reset_n = 1'b1;
    measure_rst(n);
    check("rst_hold_after_reset", 32'(n), 32'(RESET_HOLD));

    // single CPU read
    tick();
    we0 = we_cnt;
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    tick();
    cpu_req = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cpu_ack) begin lat = k; break; end
    end
    check("cpu_rd_latency", 32'(lat), 32'd3);
    check("cpu_rd_data", 32'(cpu_data), 32'h5A);
    @(negedge clk);
    check("cpu_ack_one_cycle", 32'(cpu_ack), 32'h0);
    repeat (4) @(negedge clk);
    check("cpu_data_hold", 32'(cpu_data), 32'h5A);
    check("cpu_rd_no_we", 32'(we_cnt - we0), 32'h0);

    // video and CPU both requesting continuously
    tick();
    vid_req = 1'b1; vid_addr = 16'h0100;
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    seq = '0; idx = 0;
    for (int k = 0; k < 200 && idx < 10; k++) begin
      @(negedge clk);
      if (vid_ack) begin seq[idx] = 1'b0; idx++; end
      else if (cpu_ack) begin seq[idx] = 1'b1; idx++; end
    end
    check("grant_count", 32'(idx), 32'd10);
    check("grant_order", 32'(seq), 32'(10'b1000010000));
    maxrun = 0; run = 0;
    for (int i = 0; i < 10; i++) begin
      if (seq[i]) begin
        if (run > maxrun) maxrun = run;
        run = 0;
      end else begin
        run++;
      end
    end
    check("cpu_max_wait", 32'(maxrun), 32'(STARVE_MAX));
    check("vid_rd_data", 32'(vid_data), 32'h33);
    tick();
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (6) tick();

    // download write coincident with a video request
    dn_wr = 1'b1; dn_addr = 16'h0010; dn_data = 8'hAB;
    vid_req = 1'b1; vid_addr = 16'h0010;
    tick();
    dn_wr = 1'b0;
    @(negedge clk);
    check("wr_first_we", 32'(mem_we), 32'h1);
    check("wr_first_addr", 32'(mem_addr), 32'h0010);
    check("wr_first_wdata", 32'(mem_wdata), 32'hAB);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (vid_ack) begin lat = k; break; end
    end
    check("vid_after_wr_latency", 32'(lat), 32'd4);
    check("vid_after_wr_data", 32'(vid_data), 32'hAB);
    check("mem_0010", 32'(mem[16'h0010]), 32'hAB);
    check("no_ovf_single_wr", 32'(dl_ovf), 32'h0);
    tick();
    vid_req = 1'b0;
    repeat (6) tick();

    // overflow: two bytes while a read occupies the port, during download
    dn_download = 1'b1;
    tick();
    cpu_req = 1'b1; cpu_addr = 16'h0100;
    tick();
    cpu_req = 1'b0;
    dn_wr = 1'b1; dn_addr = 16'h0020; dn_data = 8'h11;
    tick();
    dn_addr = 16'h0021; dn_data = 8'h22;
    tick();
    dn_wr = 1'b0;
    repeat (6) tick();
    check("ovf_set", 32'(dl_ovf), 32'h1);
    check("mem_0020_first_byte", 32'(mem[16'h0020]), 32'h11);
    check("mem_0021_discarded", 32'(mem[16'h0021]), 32'h77);
    check("cpu_rd_during_dl", 32'(cpu_data), 32'h33);
`ifdef ROM_DL_CHECKSUM_EN
    check("dl_count_ovf", 32'(dl_count), 32'd1);
    check("dl_sum_ovf", 32'(dl_sum), 32'h11);
`endif

    // core_rst hold with a re-raise mid-hold
    dn_download = 1'b0;
    repeat (RESET_HOLD + 5) tick();
    check("core_rst_released", 32'(core_rst), 32'h0);
    check("ovf_sticky", 32'(dl_ovf), 32'h1);
    dn_download = 1'b1;
    low = 0;
    repeat (100) begin @(negedge clk); if (!core_rst) low++; end
    check("ovf_clr_on_rise", 32'(dl_ovf), 32'h0);
`ifdef ROM_DL_CHECKSUM_EN
    check("dl_count_clr_on_rise", 32'(dl_count), 32'd0);
`endif
    tick();
    dn_download = 1'b0;
    repeat (500) begin @(negedge clk); if (!core_rst) low++; end
    tick();
    dn_download = 1'b1;
    repeat (20) begin @(negedge clk); if (!core_rst) low++; end
    tick();
    dn_download = 1'b0;
    measure_rst(n);
    check("core_rst_never_low", 32'(low), 32'd0);
    check("core_rst_hold_reload", 32'(n), 32'(RESET_HOLD));

    // reset asserted while a read is in RD_WAIT
    tick();
    a0 = ack_cnt;
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    tick();
    cpu_req = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset("async");
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    check("no_ack_after_reset", 32'(ack_cnt - a0), 32'h0);
    check("core_rst_after_reset", 32'(core_rst), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
